serial_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor.
- Processes DIGIT bits per clock through a chain of full-adder cells with a registered carry between digits.
- Successor to the single-bit combinational full adder. Adds width/digit generalisation, a subtract mode, signed-overflow detection and a start/busy/done handshake.
- Used wherever area matters more than latency; results held stable until the next operation.

---
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first, with a
// registered carry between digits and a start/busy/done handshake.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   s_q;
    logic               busy_q;
    logic               done_q;
    logic               cout_q;
    logic               ovf_q;

    logic [DIGIT-1:0]   dig_a;
    logic [DIGIT-1:0]   dig_b;
    logic [DIGIT-1:0]   dig_s;
    logic               cy;
    logic               cy_msb;
    logic [WIDTH-1:0]   s_d;
    logic               last_c;

    // Ripple one digit through DIGIT full-adder cells; cy_msb is the carry
    // into the top cell, which becomes the carry into the operand MSB on the
    // last digit.
    always_comb begin
        dig_a  = '0;
        dig_b  = '0;
        dig_s  = '0;
        cy     = carry_q;
        cy_msb = 1'b0;
        s_d    = s_q;
        for (int k = 0; k < int'(N); k++) begin
            if (cnt_q == CNT_W'(k)) begin
                dig_a = a_q[k*DIGIT +: DIGIT];
                dig_b = b_q[k*DIGIT +: DIGIT];
            end
        end
        for (int i = 0; i < int'(DIGIT); i++) begin
            cy_msb   = cy;
            dig_s[i] = dig_a[i] ^ dig_b[i] ^ cy;
            cy       = (dig_a[i] & dig_b[i]) | (cy & (dig_a[i] ^ dig_b[i]));
        end
        for (int k = 0; k < int'(N); k++) begin
            if (cnt_q == CNT_W'(k)) begin
                s_d[k*DIGIT +: DIGIT] = dig_s;
            end
        end
        last_c = (cnt_q == CNT_W'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Subtract is A + ~B + ~Cin through the same adder.
                        a_q     <= A;
                        b_q     <= B ^ {WIDTH{sub}};
                        carry_q <= Cin ^ sub;
                        s_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    s_q     <= s_d;
                    carry_q <= cy;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_c) begin
                        cout_q  <= cy;
                        ovf_q   <= cy ^ cy_msb;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder: 8-bit bit-serial instance plus an
// exhaustive sweep of a 4-bit, 2-bit-digit instance.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       start8, sub8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, s8;
    logic       start4, sub4, cin4, busy4, done4, cout4, ovf4;
    logic [3:0] a4, b4, s4;

    int passed = 0;
    int total  = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .A(a8), .B(b8),
        .Cin(cin8), .busy(busy8), .done(done8), .S(s8), .Cout(cout8), .Ovf(ovf8)
    );

    serial_adder #(.WIDTH(4), .DIGIT(2)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .A(a4), .B(b4),
        .Cin(cin4), .busy(busy4), .done(done4), .S(s4), .Cout(cout4), .Ovf(ovf4)
    );

    typedef struct {
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Drive a request (caller is away from the clock edge), let the start
    // edge pass, then scramble the inputs to show they are not re-sampled.
    task automatic start_op8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic c);
        sub8 = s; a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
        chk("busy_after_start", busy8, 1'b1);
    endtask

    // Returns the number of edges from the start edge until done is seen.
    task automatic wait_done8(output int cyc);
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int         cyc;
        logic       seen;
        logic [3:0] bb;
        logic       cc;
        logic [4:0] sum;
        logic       ov;

        vecs[0] = '{1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h05, 8'h07, 1'b1, 8'hFD, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 8'h10, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};

        rst = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        #12;
        chk("reset8", {busy8, done8, s8, cout8, ovf8}, 32'h0);
        chk("reset4", {busy4, done4, s4, cout4, ovf4}, 32'h0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start_op8(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_done8(cyc);
            chk($sformatf("latency_v%0d", i), 32'(cyc), 32'd8);
            chk($sformatf("busy_at_done_v%0d", i), busy8, 1'b0);
            chk($sformatf("sum_v%0d", i), s8, vecs[i].s);
            chk($sformatf("cout_ovf_v%0d", i), {cout8, ovf8}, {vecs[i].cout, vecs[i].ovf});
        end

        // Results hold and done drops after the one-cycle pulse.
        repeat (3) begin @(posedge clk); #1; end
        chk("hold_outputs", {busy8, done8, s8, cout8, ovf8}, {2'b00, 8'h7F, 2'b11});

        // Asynchronous reset in the middle of RUN, while digit 3 is pending.
        @(negedge clk);
        start_op8(1'b0, 8'h0F, 8'h00, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        chk("partial_before_rst", {busy8, s8}, {1'b1, 8'h07});
        #2 rst = 1'b1;
        #1;
        chk("async_rst", {busy8, done8, s8, cout8, ovf8}, 32'h0);
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 === 1'b1 || busy8 === 1'b1) seen = 1'b1;
        end
        chk("no_activity_after_rst", seen, 1'b0);
        @(negedge clk);
        start_op8(1'b0, 8'h3C, 8'h0F, 1'b1);
        wait_done8(cyc);
        chk("post_rst_latency", 32'(cyc), 32'd8);
        chk("post_rst_result", {cout8, ovf8, s8}, {2'b00, 8'h4C});

        // A start during RUN is ignored; the first operands complete.
        @(negedge clk);
        start_op8(1'b0, 8'h11, 8'h22, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8(cyc);
        chk("ignored_start_latency", 32'(cyc + 4), 32'd8);
        chk("ignored_start_sum", {cout8, ovf8, s8}, {2'b00, 8'h33});

        // Back-to-back: start issued while in DONE is accepted immediately.
        start_op8(1'b1, 8'h20, 8'h01, 1'b0);
        chk("b2b_done_dropped", done8, 1'b0);
        wait_done8(cyc);
        chk("b2b_latency", 32'(cyc), 32'd8);
        chk("b2b_result", {cout8, ovf8, s8}, {2'b10, 8'h1F});

        // Exhaustive 4-bit sweep with two-bit digits.
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    for (int c = 0; c < 2; c++) begin
                        @(negedge clk);
                        sub4 = 1'(s); a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c); start4 = 1'b1;
                        @(posedge clk); #1;
                        start4 = 1'b0;
                        cyc = 0;
                        while (done4 !== 1'b1 && cyc < 20) begin
                            @(posedge clk); #1;
                            cyc++;
                        end
                        bb  = (s != 0) ? ~4'(b) : 4'(b);
                        cc  = 1'(c) ^ 1'(s);
                        sum = 5'(a) + {1'b0, bb} + 5'(cc);
                        ov  = (a4 === 4'(a)) ? 1'b0 : 1'b0;
                        ov  = (4'(a) >> 3 == 4'(bb >> 3)) && (sum[3] != 1'(4'(a) >> 3));
                        chk($sformatf("lat4 s%0d a%0h b%0h c%0d", s, a, b, c), 32'(cyc), 32'd2);
                        chk($sformatf("res4 s%0d a%0h b%0h c%0d", s, a, b, c),
                            {cout4, ovf4, s4}, {sum[4], ov, sum[3:0]});
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
